// File: rtl/tcp_hdr_req_arbiter.sv
// tcp_hdr_req_arbiter: round-robin arbiter sharing one TCP header assembler
// between NUM_REQ header requesters. The winning request is captured into a
// single output register tagged with its requester ID.
// Optional macro TCP_HDR_ARB_PRIO0_EN gives requester 0 strict priority and
// leaves requesters 1..NUM_REQ-1 to round-robin among themselves.
//
// state | meaning
// EMPTY | val_q=0, output register free, may load a grant this cycle
// FULL  | val_q=1, holding a request; reloads only when the assembler accepts

`ifndef PORT_NUM_W
`define PORT_NUM_W 16
`endif
`ifndef SEQ_NUM_W
`define SEQ_NUM_W 32
`endif
`ifndef ACK_NUM_W
`define ACK_NUM_W 32
`endif
`ifndef FLAGS_W
`define FLAGS_W 8
`endif
`ifndef WIN_SIZE_W
`define WIN_SIZE_W 16
`endif

module tcp_hdr_req_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int REQ_ID_W = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                src_req_val,
    output logic [NUM_REQ-1:0]                src_req_rdy,
    input  logic [NUM_REQ*`PORT_NUM_W-1:0]    src_host_port,
    input  logic [NUM_REQ*`PORT_NUM_W-1:0]    src_dest_port,
    input  logic [NUM_REQ*`SEQ_NUM_W-1:0]     src_seq_num,
    input  logic [NUM_REQ*`ACK_NUM_W-1:0]     src_ack_num,
    input  logic [NUM_REQ*`FLAGS_W-1:0]       src_flags,
    input  logic [NUM_REQ*`WIN_SIZE_W-1:0]    src_window,
    output logic                              tcp_hdr_req_val,
    input  logic                              tcp_hdr_req_rdy,
    output logic [`PORT_NUM_W-1:0]            host_port,
    output logic [`PORT_NUM_W-1:0]            dest_port,
    output logic [`SEQ_NUM_W-1:0]             seq_num,
    output logic [`ACK_NUM_W-1:0]             ack_num,
    output logic [`FLAGS_W-1:0]               flags,
    output logic [`WIN_SIZE_W-1:0]            window,
    output logic [REQ_ID_W-1:0]               tcp_hdr_req_src
);

    localparam int PW  = `PORT_NUM_W;
    localparam int SW  = `SEQ_NUM_W;
    localparam int AW  = `ACK_NUM_W;
    localparam int FW  = `FLAGS_W;
    localparam int WW  = `WIN_SIZE_W;
    localparam logic [REQ_ID_W-1:0] LAST_ID = REQ_ID_W'(NUM_REQ - 1);
`ifdef TCP_HDR_ARB_PRIO0_EN
    localparam int                  RR_LO  = 1;
    localparam logic [REQ_ID_W-1:0] RR_RST = REQ_ID_W'(1);
`else
    localparam int                  RR_LO  = 0;
    localparam logic [REQ_ID_W-1:0] RR_RST = '0;
`endif

    logic                load_en;
    logic                grant_found;
    logic [REQ_ID_W-1:0] grant_idx;
    logic                hi_found, lo_found;
    logic [REQ_ID_W-1:0] hi_idx, lo_idx;

    logic                val_q, val_d;
    logic [REQ_ID_W-1:0] src_q, src_d;
    logic [REQ_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]       host_q, host_d;
    logic [PW-1:0]       dest_q, dest_d;
    logic [SW-1:0]       seq_q, seq_d;
    logic [AW-1:0]       ack_q, ack_d;
    logic [FW-1:0]       flags_q, flags_d;
    logic [WW-1:0]       win_q, win_d;

    // Output register and round-robin pointer; reset discards any held request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q    <= 1'b0;
            src_q    <= '0;
            rr_ptr_q <= RR_RST;
            host_q   <= '0;
            dest_q   <= '0;
            seq_q    <= '0;
            ack_q    <= '0;
            flags_q  <= '0;
            win_q    <= '0;
        end else begin
            val_q    <= val_d;
            src_q    <= src_d;
            rr_ptr_q <= rr_ptr_d;
            host_q   <= host_d;
            dest_q   <= dest_d;
            seq_q    <= seq_d;
            ack_q    <= ack_d;
            flags_q  <= flags_d;
            win_q    <= win_d;
        end
    end

    // Grant selection: lowest valid index at/above rr_ptr, else lowest below it (wrap)
    always_comb begin
        load_en  = rst_n && (!val_q || tcp_hdr_req_rdy);
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        // descending scan so the last hit is the lowest index in each half
        for (int i = NUM_REQ - 1; i >= RR_LO; i--) begin
            if (src_req_val[i]) begin
                if (i >= int'(rr_ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = REQ_ID_W'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = REQ_ID_W'(i);
                end
            end
        end
        grant_found = load_en && (hi_found || lo_found);
        grant_idx   = hi_found ? hi_idx : lo_idx;
`ifdef TCP_HDR_ARB_PRIO0_EN
        if (load_en && src_req_val[0]) begin
            grant_found = 1'b1;
            grant_idx   = '0;
        end
`endif
    end

    // Next-state: load on grant, drain on accept without refill, otherwise hold
    always_comb begin
        val_d    = val_q;
        src_d    = src_q;
        rr_ptr_d = rr_ptr_q;
        host_d   = host_q;
        dest_d   = dest_q;
        seq_d    = seq_q;
        ack_d    = ack_q;
        flags_d  = flags_q;
        win_d    = win_q;
        if (grant_found) begin
            val_d = 1'b1;
            src_d = grant_idx;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_idx == REQ_ID_W'(i)) begin
                    host_d  = src_host_port[i*PW +: PW];
                    dest_d  = src_dest_port[i*PW +: PW];
                    seq_d   = src_seq_num[i*SW +: SW];
                    ack_d   = src_ack_num[i*AW +: AW];
                    flags_d = src_flags[i*FW +: FW];
                    win_d   = src_window[i*WW +: WW];
                end
            end
`ifdef TCP_HDR_ARB_PRIO0_EN
            // priority grants to 0 leave the rotation among 1..NUM_REQ-1 untouched
            if (grant_idx == '0)
                rr_ptr_d = rr_ptr_q;
            else if (grant_idx == LAST_ID)
                rr_ptr_d = REQ_ID_W'(1);
            else
                rr_ptr_d = grant_idx + REQ_ID_W'(1);
`else
            if (grant_idx == LAST_ID)
                rr_ptr_d = '0;
            else
                rr_ptr_d = grant_idx + REQ_ID_W'(1);
`endif
        end else if (val_q && tcp_hdr_req_rdy) begin
            val_d = 1'b0;
        end
    end

    // Outputs: one-hot accept to the winner, registered fields to the assembler
    always_comb begin
        src_req_rdy = '0;
        if (grant_found)
            src_req_rdy[grant_idx] = 1'b1;
        tcp_hdr_req_val = val_q;
        tcp_hdr_req_src = src_q;
        host_port       = host_q;
        dest_port       = dest_q;
        seq_num         = seq_q;
        ack_num         = ack_q;
        flags           = flags_q;
        window          = win_q;
    end

endmodule

// File: tb/tb_tcp_hdr_req_arbiter.sv
// Directed bench for tcp_hdr_req_arbiter with NUM_REQ=3.

`ifndef PORT_NUM_W
`define PORT_NUM_W 16
`endif
`ifndef SEQ_NUM_W
`define SEQ_NUM_W 32
`endif
`ifndef ACK_NUM_W
`define ACK_NUM_W 32
`endif
`ifndef FLAGS_W
`define FLAGS_W 8
`endif
`ifndef WIN_SIZE_W
`define WIN_SIZE_W 16
`endif

module tb_tcp_hdr_req_arbiter;

    localparam int N = 3;

    logic                          clk;
    logic                          rst_n;
    logic [N-1:0]                  src_req_val;
    logic [N-1:0]                  src_req_rdy;
    logic [N*`PORT_NUM_W-1:0]      src_host_port;
    logic [N*`PORT_NUM_W-1:0]      src_dest_port;
    logic [N*`SEQ_NUM_W-1:0]       src_seq_num;
    logic [N*`ACK_NUM_W-1:0]       src_ack_num;
    logic [N*`FLAGS_W-1:0]         src_flags;
    logic [N*`WIN_SIZE_W-1:0]      src_window;
    logic                          tcp_hdr_req_val;
    logic                          tcp_hdr_req_rdy;
    logic [`PORT_NUM_W-1:0]        host_port;
    logic [`PORT_NUM_W-1:0]        dest_port;
    logic [`SEQ_NUM_W-1:0]         seq_num;
    logic [`ACK_NUM_W-1:0]         ack_num;
    logic [`FLAGS_W-1:0]           flags;
    logic [`WIN_SIZE_W-1:0]        window;
    logic [1:0]                    tcp_hdr_req_src;

    int n_checks = 0;
    int n_errors = 0;

    tcp_hdr_req_arbiter #(.NUM_REQ(N)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .src_req_val     (src_req_val),
        .src_req_rdy     (src_req_rdy),
        .src_host_port   (src_host_port),
        .src_dest_port   (src_dest_port),
        .src_seq_num     (src_seq_num),
        .src_ack_num     (src_ack_num),
        .src_flags       (src_flags),
        .src_window      (src_window),
        .tcp_hdr_req_val (tcp_hdr_req_val),
        .tcp_hdr_req_rdy (tcp_hdr_req_rdy),
        .host_port       (host_port),
        .dest_port       (dest_port),
        .seq_num         (seq_num),
        .ack_num         (ack_num),
        .flags           (flags),
        .window          (window),
        .tcp_hdr_req_src (tcp_hdr_req_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [15:0] hp, input logic [15:0] dp,
                           input logic [31:0] sq, input logic [31:0] ak,
                           input logic [7:0] fl, input logic [15:0] wn);
        src_host_port[i*16 +: 16] = hp;
        src_dest_port[i*16 +: 16] = dp;
        src_seq_num[i*32 +: 32]   = sq;
        src_ack_num[i*32 +: 32]   = ak;
        src_flags[i*8 +: 8]       = fl;
        src_window[i*16 +: 16]    = wn;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        src_req_val = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // expected requester tags for each test
    logic [1:0] rr_exp [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    logic [1:0] pr_exp [9] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd2, 2'd0};

    initial begin
        rst_n = 1'b0;
        src_req_val = '0;
        tcp_hdr_req_rdy = 1'b1;
        src_host_port = '0;
        src_dest_port = '0;
        src_seq_num = '0;
        src_ack_num = '0;
        src_flags = '0;
        src_window = '0;
        for (int i = 0; i < N; i++)
            set_src(i, 16'h0100 + 16'(i), 16'h0200 + 16'(i), 32'h3000 + 32'(i),
                    32'h4000 + 32'(i), 8'h50 + 8'(i), 16'h6000 + 16'(i));

        // reset state
        #2;
        chk("rst_val", tcp_hdr_req_val, 0);
        chk("rst_src", tcp_hdr_req_src, 0);
        chk("rst_host", host_port, 0);
        chk("rst_win", window, 0);
        src_req_val = 3'b111;
        #1;
        chk("rst_rdy", src_req_rdy, 0);
        src_req_val = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // single requester
        set_src(1, 16'h1F90, 16'hC350, 32'h1000, 32'h2000, 8'h10, 16'h4000);
        src_req_val = 3'b010;
        #1;
        chk("single_rdy", src_req_rdy, 3'b010);
        tick();
        src_req_val = '0;
        chk("single_val", tcp_hdr_req_val, 1);
        chk("single_src", tcp_hdr_req_src, 1);
        chk("single_host", host_port, 16'h1F90);
        chk("single_dest", dest_port, 16'hC350);
        chk("single_seq", seq_num, 32'h1000);
        chk("single_ack", ack_num, 32'h2000);
        chk("single_flags", flags, 8'h10);
        chk("single_win", window, 16'h4000);
        tick();
        chk("drain_val", tcp_hdr_req_val, 0);
        chk("drain_host_hold", host_port, 16'h1F90);

        // reload something, then async reset while FULL
        src_req_val = 3'b100;
        tick();
        src_req_val = '0;
        tcp_hdr_req_rdy = 1'b0;
        chk("pre_rst_val", tcp_hdr_req_val, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_val", tcp_hdr_req_val, 0);
        chk("async_rst_host", host_port, 0);
        chk("async_rst_seq", seq_num, 0);
        chk("async_rst_src", tcp_hdr_req_src, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tcp_hdr_req_rdy = 1'b1;
        set_src(1, 16'h0101, 16'h0201, 32'h3001, 32'h4001, 8'h51, 16'h6001);
        src_req_val = 3'b111;
        #1;
        chk("post_rst_rdy", src_req_rdy, 3'b001);
        tick();
        chk("post_rst_src", tcp_hdr_req_src, 0);
        src_req_val = '0;

`ifndef TCP_HDR_ARB_PRIO0_EN
        // round-robin, no bubbles
        do_reset();
        src_req_val = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_rdy", src_req_rdy, 3'b001 << rr_exp[k]);
            tick();
            chk("rr_val", tcp_hdr_req_val, 1);
            chk("rr_src", tcp_hdr_req_src, rr_exp[k]);
            chk("rr_host", host_port, 16'h0100 + 16'(rr_exp[k]));
        end

        // backpressure: holding src 2, rr_ptr at 0
        tcp_hdr_req_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_rdy", src_req_rdy, 0);
            tick();
            chk("bp_val", tcp_hdr_req_val, 1);
            chk("bp_src", tcp_hdr_req_src, 2);
            chk("bp_seq", seq_num, 32'h3002);
        end
        tcp_hdr_req_rdy = 1'b1;
        #1;
        chk("bp_release_rdy", src_req_rdy, 3'b001);
        tick();
        chk("bp_release_src", tcp_hdr_req_src, 0);

        // wrap: grants 1, 2, then only 0 and 2 valid -> 0, 2
        tick();
        chk("wrap_src1", tcp_hdr_req_src, 1);
        tick();
        chk("wrap_src2", tcp_hdr_req_src, 2);
        src_req_val = 3'b101;
        #1;
        chk("wrap_rdy0", src_req_rdy, 3'b001);
        tick();
        chk("wrap_src0", tcp_hdr_req_src, 0);
        #1;
        chk("wrap_rdy2", src_req_rdy, 3'b100);
        tick();
        chk("wrap_src2b", tcp_hdr_req_src, 2);
        chk("wrap_flags", flags, 8'h52);
        src_req_val = '0;
        tick();
        chk("end_drain_val", tcp_hdr_req_val, 0);
`else
        // requester 0 strict priority, 1 and 2 alternate otherwise
        do_reset();
        for (int k = 0; k < 9; k++) begin
            src_req_val = {2'b11, (k % 4 == 0)};
            #1;
            chk("prio_rdy", src_req_rdy, 3'b001 << pr_exp[k]);
            tick();
            chk("prio_src", tcp_hdr_req_src, pr_exp[k]);
        end
        src_req_val = '0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tcp_hdr_req_arbiter.md
Name: tcp_hdr_req_arbiter

Overview:
- Shares the single TCP header assembler among NUM_REQ header requesters: RX ACK generator, TX data engine and retransmit timer.
- Each requester presents a full header-field request with val/rdy.
- The block round-robin arbitrates between them and captures the winner into an output register.
- It drives the assembler request interface and tags each output with the requester ID, so downstream can route completions.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- REQ_ID_W, $clog2(NUM_REQ), width of the requester ID tag.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- src_req_val  in  NUM_REQ  per-requester request valid.
- src_req_rdy  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- src_host_port  in  NUM_REQ*`PORT_NUM_W  packed host ports; requester i occupies slice i.
- src_dest_port  in  NUM_REQ*`PORT_NUM_W  packed destination ports.
- src_seq_num  in  NUM_REQ*`SEQ_NUM_W  packed sequence numbers.
- src_ack_num  in  NUM_REQ*`ACK_NUM_W  packed ack numbers.
- src_flags  in  NUM_REQ*`FLAGS_W  packed TCP flags.
- src_window  in  NUM_REQ*`WIN_SIZE_W  packed window sizes.
- tcp_hdr_req_val  out  1  request valid to the assembler.
- tcp_hdr_req_rdy  in  1  assembler ready.
- host_port, dest_port, seq_num, ack_num, flags, window  out  `PORT_NUM_W/`PORT_NUM_W/`SEQ_NUM_W/`ACK_NUM_W/`FLAGS_W/`WIN_SIZE_W  registered fields of the granted request.
- tcp_hdr_req_src  out  REQ_ID_W  ID of the requester that owns the current output.

Behaviour:
- Reset (rst_n low, asynchronous):
  - tcp_hdr_req_val=0 and all output fields=0.
  - tcp_hdr_req_src=0.
  - Round-robin pointer rr_ptr=0.
  - src_req_rdy=0 while reset is asserted.
- Output register states:
  - EMPTY: tcp_hdr_req_val=0.
  - FULL: tcp_hdr_req_val=1.
- load_en = EMPTY, or (FULL and tcp_hdr_req_rdy). Full throughput: one header per cycle.
- Arbitration (combinational, same cycle):
  - When load_en=1 and any src_req_val is set, grant g = first set bit of src_req_val searching from rr_ptr upward, wrapping at NUM_REQ-1 to 0.
  - src_req_rdy[g]=1; all other rdy bits are 0.
  - When load_en=0, all src_req_rdy=0.
- Capture on a grant, at the clock edge:
  - Slice g of every src_* field is loaded into the output register.
  - tcp_hdr_req_src<=g; tcp_hdr_req_val<=1.
  - rr_ptr<=(g+1) mod NUM_REQ, wrapping correctly when NUM_REQ is not a power of two.
- Drain without refill: FULL, tcp_hdr_req_rdy=1, no src_req_val → tcp_hdr_req_val<=0, fields hold their last values, rr_ptr unchanged.
- Backpressure: FULL and tcp_hdr_req_rdy=0 → output fields and val stable (AXI-style hold), no grants issued.
- Latency: 1 cycle from src handshake to tcp_hdr_req_val.
- Requester obligations: once src_req_val is asserted it must be held, with fields stable, until accepted. The arbiter never drops a request.
- Fairness: with all requesters continuously valid and tcp_hdr_req_rdy=1, grants rotate 0,1,2,0,... Any requester waits at most NUM_REQ-1 grants.
- Simultaneous drain and refill in the same cycle: the new request replaces the old one with no bubble.
- Reset mid-transfer: the held request is discarded, and requesters re-present after reset.

Optional Feature:
- Macro: TCP_HDR_ARB_PRIO0_EN.
- Defined:
  - Requester 0 (RST/ACK path) has strict priority: whenever src_req_val[0]=1 and load_en=1, g=0.
  - A grant to 0 does not move rr_ptr.
  - Requesters 1..NUM_REQ-1 round-robin among themselves as above; rr_ptr only ever points at 1..NUM_REQ-1 and resets to 1.
- Not defined: all requesters are equal round-robin as in Behaviour.

Test Plan:
- Single requester: src_req_val=3'b010, port 16'h1F90→16'hC350, seq 32'h1000, ack 32'h2000, flags 8'h10, win 16'h4000, rdy=1 → src_req_rdy=3'b010 that cycle; next cycle tcp_hdr_req_val=1 with identical fields and tcp_hdr_req_src=1.
- Round-robin: all three valid continuously, rdy=1 → tcp_hdr_req_src sequence 0,1,2,0,1,2 on consecutive cycles with no bubbles.
- Backpressure: output FULL, tcp_hdr_req_rdy=0 for 5 cycles with src_req_val=3'b111 → src_req_rdy=0 and outputs stable for all 5 cycles; rdy=1 → next grant follows rr_ptr.
- Wrap with NUM_REQ=3: last grant=2, only src 0 and 2 valid → next grant 0, then 2.
- Async reset mid-transfer: rst_n low while FULL → tcp_hdr_req_val=0 and fields=0 immediately, without waiting for a clock edge; after release the first grant goes to requester 0.
- With TCP_HDR_ARB_PRIO0_EN: src 1 and 2 continuously valid, src 0 pulses every 4th cycle → src 0 granted the cycle it is valid; requesters 1 and 2 alternate in the remaining cycles.
